counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Run/pause/clear controller and rate generator for the 8-bit T-flip-flop counter.
- Produces a single-cycle count-enable tick at a switch-selected rate and an active-low clear strobe, both wired directly to the counter.
- Keeps a shadow copy of the count to support one-shot (stop at terminal count) operation.
- Drives the blank flag into the seven-segment decoders' Off input.

Parameters:
- DIV_W, 26, width of the rate-divider register.
- RATE0, 49999999, divider terminal value for rate_sel=0 (tick every RATE0+1 cycles; 1 Hz at 50 MHz).
- RATE1, 24999999, terminal value for rate_sel=1.
- RATE2, 12499999, terminal value for rate_sel=2.
- RATE3, 0, terminal value for rate_sel=3 (tick every cycle).
- TERM, 255, one-shot terminal count, 8-bit.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start/resume/restart command.
- pause  in  1  pause command.
- clear  in  1  clear command.
- one_shot  in  1  1 = stop at TERM; 0 = wrap 255->0.
- rate_sel  in  2  selects RATE0..RATE3.
- cnt_en  out  1  registered one-cycle tick to the counter's enable.
- cnt_clr_n  out  1  registered active-low clear to the counter.
- count  out  8  shadow count, equal to the counter's value.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- blank  out  1  high in IDLE; drives the display Off input.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset. All outputs are registered.
- Reset values: state=IDLE, divider=0, count=0, cnt_en=0, cnt_clr_n=0, busy=0, done=0, blank=1.
- cnt_clr_n goes to 1 on the first clk edge after reset deasserts, unless clear is asserted.
- States are IDLE, RUN, PAUSE and DONE.
- Command priority per cycle: clear > pause > start.
- clear (any state):
  - Next state IDLE; divider=0; count=0; cnt_en=0.
  - cnt_clr_n=0 for exactly the next cycle; a held clear keeps it low.
- IDLE:
  - start -> RUN, divider=0.
  - pause is ignored.
- RUN:
  - divider increments each cycle.
  - When divider >= RATE[rate_sel]: divider<=0 and cnt_en<=1 for one cycle.
  - rate_sel is sampled every cycle. A switch to a shorter rate with divider already past the new terminal ticks on the next cycle.
  - pause -> PAUSE; start is ignored.
- count tracking: count increments (mod 256) on every edge where cnt_en==1, the same edge the counter toggles.
- One-shot termination:
  - With one_shot=1, the edge where cnt_en==1 and count==TERM-1 sets count=TERM and state=DONE.
  - No further tick is generated: cnt_en is suppressed whenever one_shot=1 and (count==TERM, or cnt_en==1 with count==TERM-1). This covers RATE3=0.
  - one_shot=0: count wraps 255->0; no DONE.
  - one_shot raised while count>TERM: counting continues until count wraps and reaches TERM.
- PAUSE:
  - divider and count hold; cnt_en=0.
  - start -> RUN, resuming from the held divider value.
  - pause is ignored.
- DONE:
  - done=1; divider holds; cnt_en=0.
  - start -> RUN with count=0, divider=0, and cnt_clr_n=0 for one cycle (restart).
  - pause is ignored.
- Status outputs: busy=1 only in RUN; done=1 only in DONE; blank=1 only in IDLE. All are updated on the same edge as the state.
- Reset mid-operation: immediate return to reset values, regardless of clk.

Optional Feature:
- Macro: COUNTER_SEQ_EDGE_EN.
- Defined:
  - start, pause and clear are rising-edge detected internally through a previous-value register per input. The previous-value registers reset to 1, so an input held high through reset does not fire.
  - A command acts only in the cycle where the input is 1 and its previous value is 0, which adds no latency.
  - Suitable for level inputs from inverted KEYs.
- Undefined: the inputs are level-sensitive and act in every cycle they are high. A held clear keeps cnt_clr_n low; a held start in DONE restarts every cycle.

Test Plan:
- Reset then release, RATE0=3, rate_sel=0, start pulse -> cnt_en high 1 cycle every 4 cycles; count 0,1,2,... aligned with ticks; busy=1, blank=0.
- one_shot=1, TERM=5, rate_sel=3 (RATE3=0), start -> exactly 5 consecutive cnt_en pulses; count stops at 5; done=1, busy=0; no 6th tick.
- Running, pause at divider=2 (RATE0=3), hold 10 cycles, then start -> no ticks while paused; next tick exactly 2 cycles after resume.
- clear and start asserted in the same cycle during RUN with count=7 -> state IDLE, count=0, cnt_clr_n=0 for 1 cycle, blank=1, no tick.
- one_shot=0, rate_sel=3, run 256 ticks from 0 -> count wraps 255->0; done stays 0.
- Async reset asserted mid-period between clk edges -> all outputs at reset values immediately. With COUNTER_SEQ_EDGE_EN defined, start held high for 8 cycles yields a single transition IDLE->RUN.

Source files
------------

// File: rtl/counter_sequencer.sv
// Run/pause/clear sequencer and rate generator for the 8-bit T-flip-flop counter.
// Optional macro COUNTER_SEQ_EDGE_EN makes start/pause/clear rising-edge triggered.
module counter_sequencer #(
  parameter int DIV_W = 26,
  parameter int RATE0 = 49999999,
  parameter int RATE1 = 24999999,
  parameter int RATE2 = 12499999,
  parameter int RATE3 = 0,
  parameter int TERM  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       one_shot,
  input  logic [1:0] rate_sel,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic [7:0] count,
  output logic       busy,
  output logic       done,
  output logic       blank
);

  localparam logic [DIV_W-1:0] C_RATE0   = DIV_W'(RATE0);
  localparam logic [DIV_W-1:0] C_RATE1   = DIV_W'(RATE1);
  localparam logic [DIV_W-1:0] C_RATE2   = DIV_W'(RATE2);
  localparam logic [DIV_W-1:0] C_RATE3   = DIV_W'(RATE3);
  localparam logic [7:0]       C_TERM    = 8'(TERM);
  localparam logic [7:0]       C_TERM_M1 = 8'(TERM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_count;
  logic             r_cnt_en;
  logic             r_cnt_clr_n;
  logic             r_busy;
  logic             r_done;
  logic             r_blank;

  logic             w_start;
  logic             w_pause;
  logic             w_clear;
  logic [DIV_W-1:0] w_rate;
  logic             w_div_hit;
  logic             w_term_hit;
  logic             w_suppress;
  logic [7:0]       w_count_inc;

`ifdef COUNTER_SEQ_EDGE_EN
  // Previous values reset high so a key already held through reset never fires.
  logic r_start_prev;
  logic r_pause_prev;
  logic r_clear_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_prev <= 1'b1;
      r_pause_prev <= 1'b1;
      r_clear_prev <= 1'b1;
    end else begin
      r_start_prev <= start;
      r_pause_prev <= pause;
      r_clear_prev <= clear;
    end
  end

  assign w_start = start & ~r_start_prev;
  assign w_pause = pause & ~r_pause_prev;
  assign w_clear = clear & ~r_clear_prev;
`else
  assign w_start = start;
  assign w_pause = pause;
  assign w_clear = clear;
`endif

  always_comb begin
    w_rate = C_RATE0;
    case (rate_sel)
      2'd0:    w_rate = C_RATE0;
      2'd1:    w_rate = C_RATE1;
      2'd2:    w_rate = C_RATE2;
      2'd3:    w_rate = C_RATE3;
      default: w_rate = C_RATE0;
    endcase
  end

  // >= rather than == so a switch to a faster rate mid-period ticks at once.
  assign w_div_hit   = (r_div >= w_rate);
  assign w_term_hit  = one_shot & r_cnt_en & (r_count == C_TERM_M1);
  assign w_suppress  = one_shot & ((r_count == C_TERM) | w_term_hit);
  assign w_count_inc = r_count + {7'd0, r_cnt_en};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_count     <= '0;
      r_cnt_en    <= 1'b0;
      r_cnt_clr_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_blank     <= 1'b1;
    end else begin
      r_cnt_en    <= 1'b0;
      r_cnt_clr_n <= 1'b1;
      // The shadow follows the counter, which toggles on every edge with cnt_en high.
      r_count     <= w_count_inc;
      if (w_clear) begin
        r_state                  <= S_IDLE;
        r_div                    <= '0;
        r_count                  <= '0;
        r_cnt_clr_n              <= 1'b0;
        {r_busy, r_done, r_blank} <= 3'b001;
      end else if (w_term_hit) begin
        r_state                  <= S_DONE;
        r_count                  <= C_TERM;
        {r_busy, r_done, r_blank} <= 3'b010;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state                  <= S_RUN;
              r_div                    <= '0;
              {r_busy, r_done, r_blank} <= 3'b100;
            end
          end
          S_RUN: begin
            if (w_pause) begin
              r_state                  <= S_PAUSE;
              {r_busy, r_done, r_blank} <= 3'b000;
            end else if (w_div_hit) begin
              r_div    <= '0;
              r_cnt_en <= ~w_suppress;
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
          S_PAUSE: begin
            if (w_start) begin
              r_state                  <= S_RUN;
              {r_busy, r_done, r_blank} <= 3'b100;
            end
          end
          S_DONE: begin
            if (w_start) begin
              r_state                  <= S_RUN;
              r_div                    <= '0;
              r_count                  <= '0;
              r_cnt_clr_n              <= 1'b0;
              {r_busy, r_done, r_blank} <= 3'b100;
            end
          end
          default: begin
            r_state                  <= S_IDLE;
            {r_busy, r_done, r_blank} <= 3'b001;
          end
        endcase
      end
    end
  end

  assign cnt_en    = r_cnt_en;
  assign cnt_clr_n = r_cnt_clr_n;
  assign count     = r_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign blank     = r_blank;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed vector table, corner sequences,
// and randomized stimulus against a reference model (honours COUNTER_SEQ_EDGE_EN).
module tb_counter_sequencer;

  localparam int P_DIV_W = 8;
  localparam int P_TERM  = 5;
  localparam int RATES[4] = '{3, 2, 1, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       one_shot = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       cnt_en;
  logic       cnt_clr_n;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       blank;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_sequencer #(
    .DIV_W(P_DIV_W), .RATE0(3), .RATE1(2), .RATE2(1), .RATE3(0), .TERM(P_TERM)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .one_shot(one_shot), .rate_sel(rate_sel), .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n),
    .count(count), .busy(busy), .done(done), .blank(blank)
  );

`ifdef COUNTER_SEQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 25) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int en, input int clrn, input int cnt,
                         input int b, input int d, input int bl);
    chk({tag, ".cnt_en"}, int'(cnt_en), en);
    chk({tag, ".cnt_clr_n"}, int'(cnt_clr_n), clrn);
    chk({tag, ".count"}, int'(count), cnt);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".done"}, int'(done), d);
    chk({tag, ".blank"}, int'(blank), bl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit st, pa, cl, os;
    bit [1:0] rs;
    int en, clrn, cnt, b, d, bl;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit st, bit pa, bit cl, bit os, bit [1:0] rs,
                              int en, int clrn, int cnt, int b, int d, int bl);
    vec_t v;
    v.st = st; v.pa = pa; v.cl = cl; v.os = os; v.rs = rs;
    v.en = en; v.clrn = clrn; v.cnt = cnt; v.b = b; v.d = d; v.bl = bl;
    return v;
  endfunction

  // Reference model: phase counter per period, shadow count, and a named mode.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode, m_phase, m_count, m_tick, m_clrn;
  bit m_ps, m_pp, m_pc;

  function automatic void model_reset();
    m_mode = M_IDLE; m_phase = 0; m_count = 0; m_tick = 0; m_clrn = 0;
    m_ps = 1'b1; m_pp = 1'b1; m_pc = 1'b1;
  endfunction

  function automatic void model_edge(bit st_in, bit pa_in, bit cl_in, bit os, int rs);
    bit st, pa, cl, last;
    int new_tick;
    st = st_in; pa = pa_in; cl = cl_in;
    if (EDGE) begin
      st = st_in && !m_ps; pa = pa_in && !m_pp; cl = cl_in && !m_pc;
    end
    m_ps = st_in; m_pp = pa_in; m_pc = cl_in;
    last = os && (m_tick == 1) && (m_count == (P_TERM + 255) % 256);
    new_tick = 0;
    m_clrn = 1;
    if (m_tick == 1) m_count = (m_count + 1) % 256;
    if (cl) begin
      m_mode = M_IDLE; m_phase = 0; m_count = 0; m_clrn = 0;
    end else if (last) begin
      m_mode = M_DONE;
    end else if (m_mode == M_IDLE && st) begin
      m_mode = M_RUN; m_phase = 0;
    end else if (m_mode == M_RUN) begin
      if (pa) m_mode = M_PAUSE;
      else if (m_phase >= RATES[rs]) begin
        m_phase = 0;
        new_tick = (os && m_count == P_TERM) ? 0 : 1;
      end else m_phase++;
    end else if (m_mode == M_PAUSE && st) begin
      m_mode = M_RUN;
    end else if (m_mode == M_DONE && st) begin
      m_mode = M_RUN; m_phase = 0; m_count = 0; m_clrn = 0;
    end
    m_tick = new_tick;
  endfunction

  initial begin
    // Reset values while reset is held across edges
    repeat (2) tick();
    chk_all("reset", 0, 0, 0, 0, 0, 1);
    #2 reset = 1'b0;

    // st pa cl os rs | en clrn cnt busy done blank
    tv.push_back(mk(0,0,0,0,0, 0,1,0, 0,0,1));
    tv.push_back(mk(1,0,0,0,0, 0,1,0, 1,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0,0,0,0,0, 0,1,0, 1,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,1,0, 1,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0,0,0,0,0, 0,1,1, 1,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,1,1, 1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,2, 1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,2, 1,0,0));
    tv.push_back(mk(0,1,0,0,0, 0,1,2, 0,0,0));
    for (int i = 0; i < 10; i++) tv.push_back(mk(0,0,0,0,0, 0,1,2, 0,0,0));
    tv.push_back(mk(1,0,0,0,0, 0,1,2, 1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,2, 1,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,1,2, 1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,3, 1,0,0));
    tv.push_back(mk(1,0,1,0,0, 0,0,0, 0,0,1));
    tv.push_back(mk(0,0,0,0,0, 0,1,0, 0,0,1));
    tv.push_back(mk(1,0,0,1,3, 0,1,0, 1,0,0));
    tv.push_back(mk(0,0,0,1,3, 1,1,0, 1,0,0));
    tv.push_back(mk(0,0,0,1,3, 1,1,1, 1,0,0));
    tv.push_back(mk(0,0,0,1,3, 1,1,2, 1,0,0));
    tv.push_back(mk(0,0,0,1,3, 1,1,3, 1,0,0));
    tv.push_back(mk(0,0,0,1,3, 1,1,4, 1,0,0));
    tv.push_back(mk(0,0,0,1,3, 0,1,5, 0,1,0));
    tv.push_back(mk(0,0,0,1,3, 0,1,5, 0,1,0));
    tv.push_back(mk(0,1,0,1,3, 0,1,5, 0,1,0));
    tv.push_back(mk(1,0,0,1,3, 0,0,0, 1,0,0));
    tv.push_back(mk(0,0,0,1,3, 1,1,0, 1,0,0));
    tv.push_back(mk(0,0,1,1,3, 0,0,0, 0,0,1));
    tv.push_back(mk(0,0,0,0,0, 0,1,0, 0,0,1));

    for (int i = 0; i < tv.size(); i++) begin
      start = tv[i].st; pause = tv[i].pa; clear = tv[i].cl;
      one_shot = tv[i].os; rate_sel = tv[i].rs;
      tick();
      chk_all($sformatf("vec%0d", i), tv[i].en, tv[i].clrn, tv[i].cnt, tv[i].b, tv[i].d, tv[i].bl);
    end

    // Free-running wrap at one tick per cycle
    one_shot = 1'b0; rate_sel = 2'd3; start = 1'b1;
    tick();
    chk_all("wrap.start", 0, 1, 0, 1, 0, 0);
    start = 1'b0;
    for (int k = 1; k <= 258; k++) begin
      tick();
      chk($sformatf("wrap%0d.count", k), int'(count), (k - 1) % 256);
      chk($sformatf("wrap%0d.cnt_en", k), int'(cnt_en), 1);
      chk($sformatf("wrap%0d.done", k), int'(done), 0);
    end

    // Asynchronous reset between edges
    #3 reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0, 1);
    start = 1'b1;
    #2 reset = 1'b0;

    // Start held through reset release, then held for 8 cycles; then held clear
    tick();
    chk("held_start.cnt_clr_n", int'(cnt_clr_n), 1);
    chk("held_start.busy", int'(busy), EDGE ? 0 : 1);
    start = 1'b0;
    tick();
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("start_hold%0d.busy", i), int'(busy), 1);
    end
    clear = 1'b1;
    tick();
    chk_all("clr_hold0", 0, 0, 0, 0, 0, 1);
    tick();
    chk("clr_hold1.cnt_clr_n", int'(cnt_clr_n), EDGE ? 1 : 0);
    clear = 1'b0;
    tick();
    chk("clr_release.busy", int'(busy), EDGE ? 0 : 1);
    start = 1'b0;

    // Randomized run against the reference model
    reset = 1'b1; pause = 1'b0; clear = 1'b0; one_shot = 1'b0; rate_sel = 2'd0;
    tick();
    model_reset();
    #2 reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 14) == 0);
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) one_shot = ~one_shot;
      if ($urandom_range(0, 29) == 0) rate_sel = 2'($urandom_range(0, 3));
      tick();
      model_edge(start, pause, clear, one_shot, int'(rate_sel));
      chk_all($sformatf("rnd%0d", c), m_tick, m_clrn, m_count,
              int'(m_mode == M_RUN), int'(m_mode == M_DONE), int'(m_mode == M_IDLE));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
